// File: rtl/prim_sel_pipe_if.sv
// -----------------------------------------------------------------------------
// prim_sel_pipe_if
// Bundles the select-request handshake, the code-table write port and the
// result handshake of prim_sel_pipe.
//
// Parameters: N_SEL (select vector width), OUT_W (code width),
//             IDX_W (index / table address width)
// Signals:
//   sel_valid, sel_prim[N_SEL]    request side, driven by the master
//   sel_ready                     request back-pressure, driven by the slave
//   tbl_we, tbl_addr, tbl_wdata   code-table write port, driven by the master
//   prim_valid, prim_out, prim_idx, prim_none   result, driven by the slave
//   prim_ready                    result acceptance, driven by the master
// Modports: master (producer/consumer side), slave (the pipeline itself)
// -----------------------------------------------------------------------------
interface prim_sel_pipe_if #(
    parameter int N_SEL = 19,
    parameter int OUT_W = 32,
    parameter int IDX_W = 5
);
    logic             sel_valid;
    logic [N_SEL-1:0] sel_prim;
    logic             sel_ready;

    logic             tbl_we;
    logic [IDX_W-1:0] tbl_addr;
    logic [OUT_W-1:0] tbl_wdata;

    logic             prim_valid;
    logic             prim_ready;
    logic [OUT_W-1:0] prim_out;
    logic [IDX_W-1:0] prim_idx;
    logic             prim_none;

    modport master (
        output sel_valid, sel_prim, tbl_we, tbl_addr, tbl_wdata, prim_ready,
        input  sel_ready, prim_valid, prim_out, prim_idx, prim_none
    );

    modport slave (
        input  sel_valid, sel_prim, tbl_we, tbl_addr, tbl_wdata, prim_ready,
        output sel_ready, prim_valid, prim_out, prim_idx, prim_none
    );
endinterface

// File: rtl/prim_sel_pipe.sv
// -----------------------------------------------------------------------------
// prim_sel_pipe
// Two-stage pipeline: stage 1 priority-encodes the select vector (bit 0 wins,
// an empty vector maps to index N_SEL with none=1); stage 2 looks the index up
// in a writable code table and presents code, index and none flag.
// Full-throughput valid/ready on both sides; results hold while stalled.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    prim_sel_pipe_if.slave (request, table write, result)
//
// Optional feature: define PRIM_SEL_ECO_EN to add an OUT_W-bit patch mask,
// written at table address all-ones and XOR-ed into every hit result.
// -----------------------------------------------------------------------------
module prim_sel_pipe #(
    parameter int N_SEL = 19,
    parameter int OUT_W = 32,
    parameter int IDX_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    prim_sel_pipe_if.slave bus
);

    // Stage 1 state
    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic             s1_none;

    // Stage 2 state (drives the result side of the bus)
    logic             s2_valid;
    logic [OUT_W-1:0] s2_out;
    logic [IDX_W-1:0] s2_idx;
    logic             s2_none;

    // Priority encoder outputs
    logic [IDX_W-1:0] enc_idx;
    logic             enc_none;

    // Handshake helpers
    logic             s2_free;
    logic             s2_load;
    logic             sel_ready;

    // Code table, N_SEL hit entries plus one no-hit entry
    logic [OUT_W-1:0] tbl [N_SEL+1];
    logic [OUT_W-1:0] lookup;
    logic [OUT_W-1:0] s2_data;

    // -------------------------------------------------------------------------
    // Priority encoder: scanning from the top down leaves the lowest set bit
    // as the final assignment, so bit 0 has the highest priority.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        enc_idx  = IDX_W'(N_SEL);
        enc_none = 1'b1;
        for (int i = N_SEL - 1; i >= 0; i--) begin
            if (bus.sel_prim[i]) begin
                enc_idx  = IDX_W'(i);
                enc_none = 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Handshake. Stage 2 can take new data when empty or being drained this
    // cycle; stage 1 frees up exactly when stage 2 takes its content, so the
    // ready path has no registered bubble and one transfer per cycle is kept.
    // -------------------------------------------------------------------------
    assign s2_free   = !s2_valid || bus.prim_ready;
    assign s2_load   = s1_valid && s2_free;
    assign sel_ready = !s1_valid || s2_load;

    // -------------------------------------------------------------------------
    // Stage 1 register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_none  <= 1'b0;
        end else if (sel_ready) begin
            // Either stage 1 was empty or its content moves into stage 2 now;
            // in both cases it takes whatever is offered (possibly nothing).
            s1_valid <= bus.sel_valid;
            if (bus.sel_valid) begin
                s1_idx  <= enc_idx;
                s1_none <= enc_none;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Code table. Reads see the pre-edge contents, so a lookup that coincides
    // with a write to the same entry captures the old value.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the table needs per-entry reset values, so it is built from flops with async reset rather than a RAM.
        if (!rst_n) begin
            for (int i = 0; i < N_SEL; i++) begin
                tbl[i] <= OUT_W'(i);
            end
            tbl[N_SEL] <= '0;
        end else if (bus.tbl_we && (bus.tbl_addr <= IDX_W'(N_SEL))) begin
            tbl[bus.tbl_addr] <= bus.tbl_wdata;
        end
    end

    assign lookup = tbl[s1_idx];

`ifdef PRIM_SEL_ECO_EN
    // Patch mask lives at the all-ones table address; it only alters hits.
    logic [OUT_W-1:0] eco_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eco_mask <= '0;
        end else if (bus.tbl_we && (bus.tbl_addr == '1)) begin
            eco_mask <= bus.tbl_wdata;
        end
    end

    assign s2_data = s1_none ? lookup : (lookup ^ eco_mask);
`else
    assign s2_data = lookup;
`endif

    // -------------------------------------------------------------------------
    // Stage 2 register. Payload only changes on a load, so it holds while
    // the consumer stalls.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_out   <= '0;
            s2_idx   <= '0;
            s2_none  <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= 1'b1;
            s2_out   <= s2_data;
            s2_idx   <= s1_idx;
            s2_none  <= s1_none;
        end else if (s2_free) begin
            s2_valid <= 1'b0;
        end
    end

    assign bus.sel_ready  = sel_ready;
    assign bus.prim_valid = s2_valid;
    assign bus.prim_out   = s2_out;
    assign bus.prim_idx   = s2_idx;
    assign bus.prim_none  = s2_none;

endmodule
